// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: drives datapath selects/enables for FETCH..WRITEBACK.
// Latency lw 5, sw 4, R/addi 4, beq/j 3 cycles plus one per memory wait-state; stalls on mem_ready, traps after MEM_TIMEOUT waits.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic [3:0] state,
    output logic [1:0] fault
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t     cur, nxt;
    logic [7:0] wait_cnt;
    logic [5:0] op_q;
    logic [1:0] fault_q, fault_nxt;
    logic       mem_state, timeout;

    assign mem_state = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    // mem_ready in the final allowed cycle still completes the access normally.
    assign timeout   = !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            op_q     <= '0;
            fault_q  <= 2'b00;
        end else begin
            fault_q <= fault_nxt;
            if (cur == DECODE) op_q <= op_code;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        nxt       = cur;
        fault_nxt = fault_q;
        case (cur)
            FETCH, MEMRD, MEMWR: begin
                if (mem_ready) begin
                    nxt = (cur == FETCH) ? DECODE : (cur == MEMRD) ? MEMWB : FETCH;
                end else if (timeout) begin
                    nxt       = TRAP;
                    fault_nxt = 2'b10;
                end
            end
            DECODE: begin
                case (op_code)
                    OP_RTYPE:     nxt = EXEC;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEX;
                    default: begin
                        nxt       = TRAP;
                        fault_nxt = 2'b01;
                    end
                endcase
            end
            MEMADR:                     nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
            EXEC:                       nxt = RWB;
            ADDIEX:                     nxt = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: nxt = FETCH;
            TRAP:                       nxt = TRAP;
            default:                    nxt = TRAP;
        endcase
    end

    always_comb begin
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        case (cur)
            FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
                retire = mem_ready;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            RWB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_wr     = alu_zero;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_wr  = 1'b1;
                retire = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
        // Reset holds FETCH selects visible but suppresses every strobe.
        if (!reset) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            reg_wr = 1'b0;
            ir_wr  = 1'b0;
            pc_wr  = 1'b0;
            retire = 1'b0;
        end
    end

    assign state = cur;
    assign fault = fault_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    localparam int TMO = 4;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ADI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, i_or_d, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, alu_src_a, retire;
    logic [1:0] pc_src, alu_src_b, alu_op, fault;
    logic [3:0] state;

    int n_chk = 0;
    int n_pass = 0;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n), .op_code(op_code), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_src(pc_src), .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_wr(ir_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Instruction-level reference: cycle budget and strobe tallies from the ISA timing rules.
    function automatic int base_lat(input logic [5:0] op);
        case (op)
            OP_LW:         return 5;
            OP_BEQ, OP_J:  return 3;
            default:       return 4;
        endcase
    endfunction

    // Leaves the bench at 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        op_code = '0;
        @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_reg_wr", 32'(reg_wr), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int w1, input int w2, input logic z);
        bit is_mem = (op == OP_LW) || (op == OP_SW);
        int lat = base_lat(op) + w1 + (is_mem ? w2 : 0);
        int k = 0;
        int n_ret = 0, n_rw = 0, n_mw = 0, n_mr = 0, n_pw = 0, n_iw = 0, n_both = 0, n_func = 0;
        logic last_src_valid = 1'b0;
        logic [1:0] last_pc_src = 2'b11;
        logic rw_dst = 1'b0, rw_m2r = 1'b0;
        bit done = 0;
        while (!done && k < 40) begin
            op_code   = (k == w1 + 1) ? op : 6'($urandom);
            alu_zero  = (k == w1 + 2) ? z : 1'($urandom);
            mem_ready = (k == w1) || (k == w1 + 3 + w2);
            @(negedge clk);
            if (k == 0) chk("start_fetch", 32'(state), 0);
            if (reg_wr) begin n_rw++; rw_dst = reg_dst; rw_m2r = mem_to_reg; end
            if (mem_wr) n_mw++;
            if (mem_rd) n_mr++;
            if (ir_wr) n_iw++;
            if (mem_rd && mem_wr) n_both++;
            if (alu_op == 2'b10) n_func++;
            if (pc_wr) begin n_pw++; last_pc_src = pc_src; last_src_valid = 1'b1; end
            if (retire) begin n_ret++; done = 1; end
            k++;
            @(posedge clk);
            #1;
        end
        chk("retires", 32'(n_ret), 1);
        chk("latency", 32'(k), 32'(lat));
        chk("reg_wr_cnt", 32'(n_rw), (op == OP_LW || op == OP_R || op == OP_ADI) ? 1 : 0);
        chk("mem_wr_cnt", 32'(n_mw), (op == OP_SW) ? 32'(1 + w2) : 0);
        chk("mem_rd_cnt", 32'(n_mr), 32'(w1 + 1 + ((op == OP_LW) ? w2 + 1 : 0)));
        chk("ir_wr_cnt", 32'(n_iw), 1);
        chk("pc_wr_cnt", 32'(n_pw), 32'(1 + ((op == OP_J) ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0)));
        chk("pc_src_last", 32'(last_pc_src), last_src_valid ? ((op == OP_J) ? 2 : (op == OP_BEQ && z) ? 1 : 0) : 3);
        chk("both_strobes", 32'(n_both), 0);
        chk("funct_op_cnt", 32'(n_func), (op == OP_R) ? 1 : 0);
        if (n_rw == 1) begin
            chk("reg_dst", 32'(rw_dst), (op == OP_R) ? 1 : 0);
            chk("mem_to_reg", 32'(rw_m2r), (op == OP_LW) ? 1 : 0);
        end
        chk("no_fault", 32'(fault), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [6];
        int n_rw, n_mw, n_ret;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADI};

        do_reset();
        run_instr(OP_LW, 0, 0, 1'b0);
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 3, 1'b0);
        run_instr(OP_J, 3, 0, 1'b0);
        run_instr(OP_LW, 3, 3, 1'b0);
        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, TMO - 1)),
                      int'($urandom_range(0, TMO - 1)), 1'($urandom));

        // Fetch timeout: stuck not-ready for TMO cycles.
        do_reset();
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("tmo_wait_state", 32'(state), 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tmo_state", 32'(state), 12);
        chk("tmo_fault", 32'(fault), 2);
        chk("tmo_strobes", 32'({mem_rd, mem_wr, reg_wr, ir_wr, pc_wr, retire}), 0);
        @(posedge clk);
        #1;

        // Ready on the last permitted cycle wins over the timeout.
        do_reset();
        for (int k = 0; k < TMO; k++) begin
            mem_ready = (k == TMO - 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("late_ready_state", 32'(state), 1);
        chk("late_ready_fault", 32'(fault), 0);
        @(posedge clk);
        #1;

        // Illegal opcode traps and stays trapped.
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk);
        #1 op_code = 6'h3f;
        @(posedge clk);
        #1;
        n_rw = 0; n_mw = 0; n_ret = 0;
        for (int k = 0; k < 6; k++) begin
            op_code = 6'($urandom);
            mem_ready = 1'($urandom);
            alu_zero = 1'($urandom);
            @(negedge clk);
            if (reg_wr) n_rw++;
            if (mem_wr) n_mw++;
            if (retire) n_ret++;
            @(posedge clk);
            #1;
        end
        chk("ill_state", 32'(state), 12);
        chk("ill_fault", 32'(fault), 1);
        chk("ill_no_reg_wr", 32'(n_rw), 0);
        chk("ill_no_mem_wr", 32'(n_mw), 0);
        chk("ill_no_retire", 32'(n_ret), 0);
        do_reset();

        // Reset in the middle of a store.
        mem_ready = 1'b1;
        op_code = OP_SW;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("mid_memwr_state", 32'(state), 5);
        chk("mid_memwr_strobe", 32'(mem_wr), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_wr", 32'(mem_wr), 0);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_fault", 32'(fault), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("resume_mem_rd", 32'(mem_rd), 1);
        chk("resume_state", 32'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath: one shared ALU and one unified memory port, with IR/MDR/A/B/ALUOut holding registers.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives every datapath select and write-enable.
- Honours a memory ready handshake with wait-states and a timeout.
- Flags illegal opcodes and memory timeouts through a sticky fault trap.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready cycles tolerated in a memory state before trapping; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op_code  in  6  IR[31:26]; sampled only in DECODE.
- alu_zero  in  1  ALU zero flag; used only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_wr  out  1  PC load enable.
- pc_src  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = {PC[31:28], addr26, 2'b00}.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- ir_wr  out  1  IR load enable.
- reg_dst  out  1  RF write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  RF write data: 0 = ALUOut, 1 = MDR.
- reg_wr  out  1  RF write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  to the ALU control decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- state  out  4  current state encoding, for debug.
- fault  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; sticky until reset.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- While reset=0: state=FETCH, fault=00, wait counter=0, all outputs 0.
  - Exception: FETCH combinational outputs (listed below) are visible during reset.
  - mem_rd is nevertheless forced to 0 while reset=0.
- Output defaults: every output is 0 unless listed below. Outputs are decoded from state; pc_wr and ir_wr are additionally qualified by inputs.
- FETCH:
  - Outputs: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_wr=pc_wr=1 only in a cycle with mem_ready=1.
  - Next state: DECODE on mem_ready, otherwise stay.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by op_code: 000000 -> EXEC; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDIEX.
  - Any other opcode -> TRAP with fault=01.
- MEMADR: alu_src_a=1, alu_src_b=10. Next state: lw -> MEMRD, sw -> MEMWR.
  - Opcode is latched in DECODE into an internal register; the op_code input is ignored after DECODE.
- MEMRD: mem_rd=1, i_or_d=1. Next state: MEMWB on mem_ready, otherwise stay.
- MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0, retire=1. Next state: FETCH.
- MEMWR: mem_wr=1, i_or_d=1. retire=1 in the cycle mem_ready=1, then FETCH; otherwise stay.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state: RWB.
- RWB: reg_wr=1, reg_dst=1, mem_to_reg=0, retire=1. Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_wr=alu_zero, retire=1.
  - Next state: FETCH.
- JUMP: pc_src=10, pc_wr=1, retire=1. Next state: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: ADDIWB.
- ADDIWB: reg_wr=1, reg_dst=0, mem_to_reg=0, retire=1. Next state: FETCH.
- Wait counter (8-bit):
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - If mem_ready=0 and counter==MEM_TIMEOUT-1 -> TRAP with fault=10.
  - mem_ready=1 in that same cycle wins: normal transition, no fault.
- TRAP: all strobes 0, no retire; stays in TRAP until reset.
- Latency with zero wait-states, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait-state adds 1.
- Strobe rule: mem_rd and mem_wr are never both 1. mem_wr is never asserted outside MEMWR.
- Reset mid-instruction: immediate return to FETCH; no partial reg_wr or mem_wr is issued after reset asserts.

Test Plan:
- Reset, mem_ready=1, lw (op 100011) -> states 0,1,2,3,4,0. reg_wr=1 only in the state-4 cycle with mem_to_reg=1. One retire pulse; 5 cycles total.
- R-type (op 000000), then beq (000100) with alu_zero=1, then beq with alu_zero=0:
  - R-type: alu_op=10 in EXEC; RWB has reg_dst=1.
  - First beq: pc_wr=1, pc_src=01.
  - Second beq: pc_wr=0.
  - Latencies 4/3/3 cycles.
- sw with mem_ready held 0 for 3 cycles in MEMWR -> MEMWR persists for 4 cycles with mem_wr=1. retire only in the 4th cycle; then FETCH.
- MEM_TIMEOUT=4, mem_ready stuck 0 from FETCH -> TRAP after exactly 4 cycles, fault=10, all strobes 0. mem_ready=1 on the 4th cycle instead -> DECODE, no fault.
- op_code=111111 in DECODE -> TRAP, fault=01, no reg_wr/mem_wr ever. Recovery only after reset pulses low; fault returns to 00.
- Assert reset low during MEMWR of sw -> mem_wr drops in the same cycle, state=0, fault=00. After release, fetch resumes with mem_rd=1.
